// File: rtl/rns_fwd_conv_seq_if.sv
// Handshake and residue bundle for the serial binary-to-RNS converter.
// The master side is the environment; the slave side is the converter.
interface rns_fwd_conv_seq_if #(
  parameter int N_SIZE = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [N_SIZE-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [4:0]        r32;
  logic [4:0]        r17;
  logic [3:0]        r13;
  logic [3:0]        r11;
  logic              busy;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, r32, r17, r13, r11, busy
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, r32, r17, r13, r11, busy
  );
endinterface

// File: rtl/rns_fwd_conv_seq.sv
// Serial binary-to-RNS forward converter for moduli {32, 17, 13, 11}.
// One MSB-first shifter feeds three lockstep modular accumulators; mod 32 is the low bits.
module rns_fwd_conv_seq #(
  parameter int N_SIZE = 16
) (
  input  logic               clk,
  input  logic               rst,
  rns_fwd_conv_seq_if.slave  bus
);

  localparam int CW = (N_SIZE > 1) ? $clog2(N_SIZE) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]        state;
  logic [N_SIZE-1:0] shreg;
  logic [CW-1:0]     cnt;
  logic [4:0]        r32_q;
  logic [4:0]        acc17;
  logic [3:0]        acc13;
  logic [3:0]        acc11;
  logic [4:0]        r32_o;
  logic [4:0]        r17_o;
  logic [3:0]        r13_o;
  logic [3:0]        r11_o;

  logic              msb;
  logic              accept;
  logic [4:0]        acc17_nxt;
  logic [3:0]        acc13_nxt;
  logic [3:0]        acc11_nxt;

  // acc < m keeps 2*acc+b below 2m, so a single conditional subtract is enough.
  function automatic logic [4:0] step17(input logic [4:0] acc, input logic b);
    logic [5:0] t;
    t = {acc, b};
    step17 = (t >= 6'd17) ? 5'(t - 6'd17) : t[4:0];
  endfunction

  function automatic logic [3:0] step13(input logic [3:0] acc, input logic b);
    logic [4:0] t;
    t = {acc, b};
    step13 = (t >= 5'd13) ? 4'(t - 5'd13) : t[3:0];
  endfunction

  function automatic logic [3:0] step11(input logic [3:0] acc, input logic b);
    logic [4:0] t;
    t = {acc, b};
    step11 = (t >= 5'd11) ? 4'(t - 5'd11) : t[3:0];
  endfunction

  assign msb       = shreg[N_SIZE-1];
  assign acc17_nxt = step17(acc17, msb);
  assign acc13_nxt = step13(acc13, msb);
  assign acc11_nxt = step11(acc11, msb);

  assign bus.in_ready  = ~rst & ((state == IDLE) | ((state == DONE) & bus.out_ready));
  assign accept        = bus.in_valid & bus.in_ready;
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.r32       = r32_o;
  assign bus.r17       = r17_o;
  assign bus.r13       = r13_o;
  assign bus.r11       = r11_o;

  // An accept is only possible in IDLE or in DONE with out_ready, so it takes priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
      r32_q <= '0;
      acc17 <= '0;
      acc13 <= '0;
      acc11 <= '0;
      r32_o <= '0;
      r17_o <= '0;
      r13_o <= '0;
      r11_o <= '0;
    end else if (accept) begin
      state <= RUN;
      shreg <= bus.in_data;
      r32_q <= bus.in_data[4:0];
      cnt   <= CW'(N_SIZE - 1);
      acc17 <= '0;
      acc13 <= '0;
      acc11 <= '0;
    end else begin
      case (state)
        RUN: begin
          acc17 <= acc17_nxt;
          acc13 <= acc13_nxt;
          acc11 <= acc11_nxt;
          shreg <= {shreg[N_SIZE-2:0], 1'b0};
          cnt   <= cnt - 1'b1;
          if (cnt == '0) begin
            r32_o <= r32_q;
            r17_o <= acc17_nxt;
            r13_o <= acc13_nxt;
            r11_o <= acc11_nxt;
            state <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state <= IDLE;
          end
        end
        IDLE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rns_fwd_conv_seq.sv
// Self-checking bench for rns_fwd_conv_seq: directed corner cases plus a randomized
// regression compared against plain modulo arithmetic.
module tb_rns_fwd_conv_seq;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  rns_fwd_conv_seq_if #(.N_SIZE(16)) ifc();

  rns_fwd_conv_seq #(.N_SIZE(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic checkResidues(input string tag, input logic [15:0] data);
    checkOutput({tag, "_r32"}, ifc.r32, data % 32);
    checkOutput({tag, "_r17"}, ifc.r17, data % 17);
    checkOutput({tag, "_r13"}, ifc.r13, data % 13);
    checkOutput({tag, "_r11"}, ifc.r11, data % 11);
  endtask

  task automatic waitReady();
    int n;
    n = 0;
    while (!ifc.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("accept_ready", ifc.in_ready, 1);
  endtask

  // One full transaction: accept, latency, residues, optional stall, handshake and busy length.
  task automatic applyStimulus(input logic [15:0] data, input int stall);
    int edges;
    int busyCnt;
    ifc.out_ready = (stall == 0);
    ifc.in_data   = data;
    ifc.in_valid  = 1'b1;
    waitReady();
    @(posedge clk);
    #1;
    ifc.in_valid = 1'b0;
    ifc.in_data  = 16'($urandom);
    edges   = 0;
    busyCnt = 0;
    while (!ifc.out_valid && edges < 40) begin
      if (ifc.busy) busyCnt++;
      @(posedge clk);
      #1;
      edges++;
    end
    checkOutput("latency", edges, 16);
    checkResidues("res", data);
    for (int i = 0; i < stall; i++) begin
      if (ifc.busy) busyCnt++;
      checkOutput("stall_in_ready", ifc.in_ready, 0);
      @(posedge clk);
      #1;
      checkOutput("stall_valid", ifc.out_valid, 1);
      checkResidues("stall_hold", data);
    end
    ifc.out_ready = 1'b1;
    if (ifc.busy) busyCnt++;
    @(posedge clk);
    #1;
    checkOutput("valid_drop", ifc.out_valid, 0);
    checkOutput("busy_cycles", busyCnt, 17 + stall);
    checkOutput("busy_idle", ifc.busy, 0);
    checkResidues("after_hs", data);
  endtask

  task automatic backToBack(input logic [15:0] first, input logic [15:0] second);
    int edges;
    ifc.out_ready = 1'b1;
    ifc.in_data   = first;
    ifc.in_valid  = 1'b1;
    waitReady();
    @(posedge clk);
    #1;
    ifc.in_data = second;
    edges = 0;
    while (!ifc.out_valid && edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
    end
    checkOutput("b2b_latency", edges, 16);
    checkResidues("b2b_first", first);
    checkOutput("b2b_in_ready", ifc.in_ready, 1);
    @(posedge clk);
    #1;
    ifc.in_valid = 1'b0;
    checkOutput("b2b_valid_drop", ifc.out_valid, 0);
    checkOutput("b2b_busy", ifc.busy, 1);
    edges = 1;
    while (!ifc.out_valid && edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
    end
    checkOutput("b2b_gap", edges, 17);
    checkResidues("b2b_second", second);
    @(posedge clk);
    #1;
    checkOutput("b2b_end", ifc.out_valid, 0);
  endtask

  task automatic resetMidRun(input logic [15:0] data);
    int spurious;
    ifc.out_ready = 1'b1;
    ifc.in_data   = data;
    ifc.in_valid  = 1'b1;
    waitReady();
    @(posedge clk);
    #1;
    ifc.in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_valid", ifc.out_valid, 0);
    checkOutput("mid_rst_busy", ifc.busy, 0);
    checkOutput("mid_rst_ready", ifc.in_ready, 0);
    checkOutput("mid_rst_r32", ifc.r32, 0);
    checkOutput("mid_rst_r17", ifc.r17, 0);
    checkOutput("mid_rst_r13", ifc.r13, 0);
    checkOutput("mid_rst_r11", ifc.r11, 0);
    @(negedge clk);
    rst = 1'b0;
    spurious = 0;
    repeat (20) begin
      @(negedge clk);
      if (ifc.out_valid) spurious++;
    end
    checkOutput("no_stale_valid", spurious, 0);
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    rst           = 1'b1;
    ifc.in_valid  = 1'b0;
    ifc.in_data   = '0;
    ifc.out_ready = 1'b1;
    #1;
    checkOutput("rst_valid", ifc.out_valid, 0);
    checkOutput("rst_busy", ifc.busy, 0);
    checkOutput("rst_ready", ifc.in_ready, 0);
    checkOutput("rst_r32", ifc.r32, 0);
    checkOutput("rst_r17", ifc.r17, 0);
    checkOutput("rst_r13", ifc.r13, 0);
    checkOutput("rst_r11", ifc.r11, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idle_ready", ifc.in_ready, 1);

    applyStimulus(16'd0, 0);
    applyStimulus(16'hFFFF, 0);
    applyStimulus(16'd1000, 0);
    applyStimulus(16'd12345, 10);
    backToBack(16'd1000, 16'hFFFF);
    resetMidRun(16'd12345);
    applyStimulus(16'd1000, 0);

    for (int i = 0; i < 1500; i++) begin
      applyStimulus(16'($urandom), int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
